// File: rtl/mme_ctrl_pkg.sv
// Shared definitions for the MME control block: register offsets, FSM
// states and STATUS bit positions.
package mme_ctrl_pkg;

  // Byte offsets of the APB registers (paddr[1:0] is ignored on decode)
  localparam logic [11:0] OFF_VERSION = 12'h000;
  localparam logic [11:0] OFF_MAT_A   = 12'h004;
  localparam logic [11:0] OFF_MAT_B   = 12'h008;
  localparam logic [11:0] OFF_MAT_C   = 12'h00C;
  localparam logic [11:0] OFF_WIDTH   = 12'h010;
  localparam logic [11:0] OFF_CMD     = 12'h014;
  localparam logic [11:0] OFF_STATUS  = 12'h018;
  localparam logic [11:0] OFF_IRQ_EN  = 12'h01C;
  localparam logic [11:0] OFF_CYCLES  = 12'h020;

  // STATUS register bit positions
  localparam int STATUS_BUSY_BIT = 0;
  localparam int STATUS_DONE_BIT = 1;
  localparam int STATUS_ERR_BIT  = 2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_BUSY   = 2'd2
  } state_e;

  // Word-granular address compare
  function automatic logic word_match(input logic [11:0] addr, input logic [11:0] off);
    return addr[11:2] == off[11:2];
  endfunction

endpackage

// File: rtl/mme_ctrl_regs.sv
// APB decode and configuration register file. Produces the start request
// and the STATUS write-one-to-clear strobes for the sequencing logic.
module mme_ctrl_regs
  import mme_ctrl_pkg::*;
#(
  parameter logic [31:0] ADDR_A_RST = 32'h0000_0000,
  parameter logic [31:0] ADDR_B_RST = 32'h0000_1000,
  parameter logic [31:0] ADDR_C_RST = 32'h0000_2000,
  parameter logic [7:0]  WIDTH_RST  = 8'h32,
  parameter logic [31:0] VERSION    = 32'h0001_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:0] paddr_i,
  input  logic        psel_i,
  input  logic        penable_i,
  input  logic        pwrite_i,
  input  logic [31:0] pwdata_i,
  output logic [31:0] prdata_o,
  output logic        pslverr_o,
  input  logic        busy_i,
  input  logic        done_flag_i,
  input  logic        err_flag_i,
  input  logic [31:0] cycles_i,
  output logic [31:0] mat_a_o,
  output logic [31:0] mat_b_o,
  output logic [31:0] mat_c_o,
  output logic [7:0]  width_o,
  output logic        irq_en_o,
  output logic        start_req_o,
  output logic        w1c_done_o,
  output logic        w1c_err_o
);

  logic [31:0] mat_a_q, mat_a_d;
  logic [31:0] mat_b_q, mat_b_d;
  logic [31:0] mat_c_q, mat_c_d;
  logic [7:0]  width_q, width_d;
  logic        irq_en_q, irq_en_d;

  logic access, wr_acc, cfg_we, cfg_sel, mapped;
  logic sel_ver, sel_a, sel_b, sel_c, sel_width, sel_cmd, sel_status, sel_irq, sel_cyc;

  assign access = psel_i & penable_i;
  assign wr_acc = access & pwrite_i;

  assign sel_ver    = word_match(paddr_i, OFF_VERSION);
  assign sel_a      = word_match(paddr_i, OFF_MAT_A);
  assign sel_b      = word_match(paddr_i, OFF_MAT_B);
  assign sel_c      = word_match(paddr_i, OFF_MAT_C);
  assign sel_width  = word_match(paddr_i, OFF_WIDTH);
  assign sel_cmd    = word_match(paddr_i, OFF_CMD);
  assign sel_status = word_match(paddr_i, OFF_STATUS);
  assign sel_irq    = word_match(paddr_i, OFF_IRQ_EN);
  assign sel_cyc    = word_match(paddr_i, OFF_CYCLES);

  assign mapped  = sel_ver | sel_a | sel_b | sel_c | sel_width | sel_cmd |
                   sel_status | sel_irq | sel_cyc;
  // Configuration and CMD are locked while the engine is running
  assign cfg_sel = sel_a | sel_b | sel_c | sel_width | sel_cmd;
  assign cfg_we  = wr_acc & ~busy_i;

  assign pslverr_o   = access & (~mapped | (pwrite_i & busy_i & cfg_sel));
  assign start_req_o = cfg_we & sel_cmd & pwdata_i[0];
  assign w1c_done_o  = wr_acc & sel_status & pwdata_i[STATUS_DONE_BIT];
  assign w1c_err_o   = wr_acc & sel_status & pwdata_i[STATUS_ERR_BIT];

  assign mat_a_o  = mat_a_q;
  assign mat_b_o  = mat_b_q;
  assign mat_c_o  = mat_c_q;
  assign width_o  = width_q;
  assign irq_en_o = irq_en_q;

  // Next-state for the writable registers
  always_comb begin
    mat_a_d  = mat_a_q;
    mat_b_d  = mat_b_q;
    mat_c_d  = mat_c_q;
    width_d  = width_q;
    irq_en_d = irq_en_q;
    if (cfg_we && sel_a)     mat_a_d = pwdata_i;
    if (cfg_we && sel_b)     mat_b_d = pwdata_i;
    if (cfg_we && sel_c)     mat_c_d = pwdata_i;
    if (cfg_we && sel_width) width_d = pwdata_i[7:0];
    if (wr_acc && sel_irq)   irq_en_d = pwdata_i[0];
  end

  // Register file state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mat_a_q  <= ADDR_A_RST;
      mat_b_q  <= ADDR_B_RST;
      mat_c_q  <= ADDR_C_RST;
      width_q  <= WIDTH_RST;
      irq_en_q <= 1'b0;
    end else begin
      mat_a_q  <= mat_a_d;
      mat_b_q  <= mat_b_d;
      mat_c_q  <= mat_c_d;
      width_q  <= width_d;
      irq_en_q <= irq_en_d;
    end
  end

  // Read mux, only driven during the access phase
  always_comb begin
    prdata_o = '0;
    if (access) begin
      if (sel_ver)    prdata_o = VERSION;
      if (sel_a)      prdata_o = mat_a_q;
      if (sel_b)      prdata_o = mat_b_q;
      if (sel_c)      prdata_o = mat_c_q;
      if (sel_width)  prdata_o = {24'd0, width_q};
      if (sel_status) begin
        prdata_o[STATUS_BUSY_BIT] = busy_i;
        prdata_o[STATUS_DONE_BIT] = done_flag_i;
        prdata_o[STATUS_ERR_BIT]  = err_flag_i;
      end
      if (sel_irq)    prdata_o = {31'd0, irq_en_q};
      if (sel_cyc)    prdata_o = cycles_i;
    end
  end

endmodule

// File: rtl/mme_ctrl.sv
// MME control top: launch/busy/done sequencing, status flags, interrupt
// and execution cycle counter around the APB register file.
module mme_ctrl
  import mme_ctrl_pkg::*;
#(
  parameter logic [31:0] ADDR_A_RST = 32'h0000_0000,
  parameter logic [31:0] ADDR_B_RST = 32'h0000_1000,
  parameter logic [31:0] ADDR_C_RST = 32'h0000_2000,
  parameter logic [7:0]  WIDTH_RST  = 8'h32,
  parameter logic [31:0] VERSION    = 32'h0001_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:0] paddr_i,
  input  logic        psel_i,
  input  logic        penable_i,
  input  logic        pwrite_i,
  input  logic [31:0] pwdata_i,
  output logic [31:0] prdata_o,
  output logic        pready_o,
  output logic        pslverr_o,
  output logic [31:0] mat_a_addr_o,
  output logic [31:0] mat_b_addr_o,
  output logic [31:0] mat_c_addr_o,
  output logic [7:0]  mat_width_o,
  output logic        start_o,
  input  logic        done_i,
  output logic        irq_o
);

  state_e      state_q, state_d;
  logic [31:0] cycles_q, cycles_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic        busy;
  logic        start_req, w1c_done, w1c_err, irq_en;
  logic        launch_ok, err_set, done_set;

  assign pready_o = 1'b1;

  mme_ctrl_regs #(
    .ADDR_A_RST (ADDR_A_RST),
    .ADDR_B_RST (ADDR_B_RST),
    .ADDR_C_RST (ADDR_C_RST),
    .WIDTH_RST  (WIDTH_RST),
    .VERSION    (VERSION)
  ) u_regs (
    .clk         (clk),
    .rst_n       (rst_n),
    .paddr_i     (paddr_i),
    .psel_i      (psel_i),
    .penable_i   (penable_i),
    .pwrite_i    (pwrite_i),
    .pwdata_i    (pwdata_i),
    .prdata_o    (prdata_o),
    .pslverr_o   (pslverr_o),
    .busy_i      (busy),
    .done_flag_i (done_q),
    .err_flag_i  (err_q),
    .cycles_i    (cycles_q),
    .mat_a_o     (mat_a_addr_o),
    .mat_b_o     (mat_b_addr_o),
    .mat_c_o     (mat_c_addr_o),
    .width_o     (mat_width_o),
    .irq_en_o    (irq_en),
    .start_req_o (start_req),
    .w1c_done_o  (w1c_done),
    .w1c_err_o   (w1c_err)
  );

  // A start with a zero width is rejected and flagged instead of launched
  assign launch_ok = start_req & (state_q == ST_IDLE) & (mat_width_o != 8'd0);
  assign err_set   = start_req & (state_q == ST_IDLE) & (mat_width_o == 8'd0);
  assign done_set  = (state_q == ST_BUSY) & done_i;

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (launch_ok) state_d = ST_LAUNCH;
      ST_LAUNCH: state_d = ST_BUSY;
      ST_BUSY:   if (done_i) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    start_o = (state_q == ST_LAUNCH);
    busy    = (state_q != ST_IDLE);
  end

  // Flag and counter next-state; sets take priority over W1C clears
  always_comb begin
    cycles_d = cycles_q;
    if (launch_ok)                        cycles_d = '0;
    else if (busy && cycles_q != '1)      cycles_d = cycles_q + 32'd1;
    done_d = done_set | (done_q & ~w1c_done & ~launch_ok);
    err_d  = err_set  | (err_q  & ~w1c_err);
  end

  // Flag and counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycles_q <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      cycles_q <= cycles_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign irq_o = done_q & irq_en;

endmodule

// File: tb/tb_mme_ctrl.sv
// Directed bench for mme_ctrl: reset values, configure/run, W1C, busy
// protection, error/decode and reset during a run.
module tb_mme_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [11:0] paddr;
  logic        psel, penable, pwrite;
  logic [31:0] pwdata, prdata;
  logic        pready, pslverr;
  logic [31:0] mat_a, mat_b, mat_c;
  logic [7:0]  mat_w;
  logic        start_o, done_i, irq_o;

  int errors = 0;
  int checks = 0;
  int start_cnt = 0;
  int c0;
  logic [31:0] rd;
  logic        se;

  mme_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .paddr_i      (paddr),
    .psel_i       (psel),
    .penable_i    (penable),
    .pwrite_i     (pwrite),
    .pwdata_i     (pwdata),
    .prdata_o     (prdata),
    .pready_o     (pready),
    .pslverr_o    (pslverr),
    .mat_a_addr_o (mat_a),
    .mat_b_addr_o (mat_b),
    .mat_c_addr_o (mat_c),
    .mat_width_o  (mat_w),
    .start_o      (start_o),
    .done_i       (done_i),
    .irq_o        (irq_o)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (start_o) start_cnt <= start_cnt + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Both transfers start just after a rising edge and return one cycle
  // after the access cycle.
  task automatic apb_write(input logic [11:0] a, input logic [31:0] d, output logic err);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = d;
    tick(1);
    penable = 1'b1;
    @(negedge clk);
    err = pslverr;
    tick(1);
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    $display("apb wr addr=%h data=%h slverr=%0b", a, d, err);
  endtask

  task automatic apb_read(input logic [11:0] a, output logic [31:0] d, output logic err);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = a;
    tick(1);
    penable = 1'b1;
    @(negedge clk);
    d = prdata; err = pslverr;
    tick(1);
    psel = 1'b0; penable = 1'b0;
    $display("apb rd addr=%h data=%h slverr=%0b", a, d, err);
  endtask

  initial begin
    rst_n = 1'b0; paddr = '0; psel = 0; penable = 0; pwrite = 0; pwdata = '0; done_i = 0;
    tick(3);
    rst_n = 1'b1;

    // Reset state
    @(negedge clk);
    chk("rst_irq", irq_o, 0);
    chk("rst_start", start_o, 0);
    chk("rst_mat_b_o", mat_b, 32'h1000);
    chk("rst_pready", pready, 1);
    tick(1);
    apb_read(12'h000, rd, se); chk("rst_version", rd, 32'h0001_0000); chk("rst_version_err", se, 0);
    apb_read(12'h008, rd, se); chk("rst_mat_b", rd, 32'h1000);
    apb_read(12'h010, rd, se); chk("rst_width", rd, 32'h32);
    apb_read(12'h018, rd, se); chk("rst_status", rd, 0); chk("rst_status_err", se, 0);

    // Configure and run; start_o in cycle L, done_i driven in L+20
    apb_write(12'h004, 32'h100, se);
    apb_write(12'h010, 32'd8, se);
    apb_write(12'h01C, 32'd1, se);
    c0 = start_cnt;
    apb_write(12'h014, 32'd1, se); chk("cmd_idle_err", se, 0);
    @(negedge clk); chk("launch_start", start_o, 1);
    tick(1);
    @(negedge clk); chk("launch_one_cycle", start_o, 0);
    tick(1);
    apb_read(12'h018, rd, se); chk("status_busy", rd, 32'h1);
    apb_write(12'h00C, 32'hDEAD, se); chk("busy_wr_matc_err", se, 1);
    apb_write(12'h014, 32'd1, se); chk("busy_wr_cmd_err", se, 1);
    apb_read(12'h00C, rd, se); chk("busy_matc_kept", rd, 32'h2000);
    tick(10);
    done_i = 1'b1;
    tick(1);
    done_i = 1'b0;
    @(negedge clk);
    chk("run_irq", irq_o, 1);
    chk("run_mat_a_o", mat_a, 32'h100);
    chk("run_mat_c_o", mat_c, 32'h2000);
    tick(1);
    apb_read(12'h018, rd, se); chk("run_status", rd, 32'h2);
    apb_read(12'h020, rd, se); chk("run_cycles", rd, 32'd21);
    chk("run_start_count", start_cnt - c0, 1);

    // W1C of done drops the interrupt
    apb_write(12'h018, 32'h2, se);
    @(negedge clk); chk("w1c_irq", irq_o, 0);
    tick(1);
    apb_read(12'h018, rd, se); chk("w1c_status", rd, 0);

    // done_i and W1C of done in the same cycle: set wins
    apb_write(12'h014, 32'd1, se);
    tick(5);
    psel = 1'b1; pwrite = 1'b1; paddr = 12'h018; pwdata = 32'h2;
    tick(1);
    penable = 1'b1; done_i = 1'b1;
    tick(1);
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0; done_i = 1'b0;
    $display("apb wr addr=018 data=00000002 with done_i");
    apb_read(12'h018, rd, se); chk("race_status", rd, 32'h2);
    apb_read(12'h020, rd, se); chk("race_cycles", rd, 32'd7);
    chk("race_irq", irq_o, 1);

    // Zero width start is rejected with err
    apb_write(12'h018, 32'h2, se);
    apb_write(12'h010, 32'd0, se);
    c0 = start_cnt;
    apb_write(12'h014, 32'd1, se);
    tick(2);
    chk("err_no_start", start_cnt - c0, 0);
    apb_read(12'h018, rd, se); chk("err_status", rd, 32'h4);
    apb_write(12'h018, 32'h4, se);
    apb_read(12'h018, rd, se); chk("err_w1c", rd, 0);
    apb_read(12'h03C, rd, se); chk("unmapped_data", rd, 0); chk("unmapped_err", se, 1);
    apb_read(12'h006, rd, se); chk("low_bits_ignored", rd, 32'h100);

    // Reset during BUSY
    apb_write(12'h010, 32'd4, se);
    apb_write(12'h004, 32'h555, se);
    apb_write(12'h014, 32'd1, se);
    tick(3);
    rst_n = 1'b0;
    c0 = start_cnt;
    @(negedge clk);
    chk("mrst_start", start_o, 0);
    chk("mrst_mat_a", mat_a, 32'h0);
    chk("mrst_width", mat_w, 32'h32);
    chk("mrst_irq", irq_o, 0);
    tick(1);
    rst_n = 1'b1;
    tick(1);
    done_i = 1'b1;
    tick(1);
    done_i = 1'b0;
    tick(2);
    chk("mrst_no_start", start_cnt - c0, 0);
    chk("mrst_irq_after", irq_o, 0);
    apb_read(12'h018, rd, se); chk("mrst_status", rd, 0);
    apb_read(12'h020, rd, se); chk("mrst_cycles", rd, 0);
    apb_read(12'h01C, rd, se); chk("mrst_irq_en", rd, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mme_ctrl.md
# mme_ctrl

APB-programmable control and sequencing block for the matrix-multiply engine (MME). It holds the matrix A/B/C base addresses and the matrix width, and launches the DMA/systolic-array engine with a one-cycle start pulse. It tracks the busy/done status, raises a maskable interrupt and counts execution cycles. It sits between the APB slave port of MME_TOP and the engine's configuration/start/done interface, replacing the hard-wired configuration constants.

## Interface
Parameters:
- ADDR_A_RST, 32'h0000_0000, reset value of the matrix A base address
- ADDR_B_RST, 32'h0000_1000, reset value of the matrix B base address
- ADDR_C_RST, 32'h0000_2000, reset value of the matrix C base address
- WIDTH_RST, 8'h32, reset value of the matrix width
- VERSION, 32'h0001_0000, value returned by the read-only version register

Ports:
- clk  in  1  single clock; all logic is on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- apb_if  APB.slave  —  paddr[11:0], psel, penable, pwrite, pwdata[31:0], prdata[31:0], pready, pslverr
- mat_a_addr_o  out  32  matrix A base address to the engine
- mat_b_addr_o  out  32  matrix B base address to the engine
- mat_c_addr_o  out  32  matrix C base address to the engine
- mat_width_o  out  8  matrix width in elements
- start_o  out  1  one-cycle engine launch pulse
- done_i  in  1  one-cycle engine completion pulse
- irq_o  out  1  level interrupt: done flag AND irq enable

## Operation
Register map (byte offsets; paddr[1:0] ignored):
- 0x00 VERSION (RO)
- 0x04 MAT_A (RW)
- 0x08 MAT_B (RW)
- 0x0C MAT_C (RW)
- 0x10 WIDTH (RW, bits [7:0]; upper bits read 0)
- 0x14 CMD (WO): bit0 = start; reads 0
- 0x18 STATUS: bit0 busy (RO); bit1 done (W1C); bit2 err (W1C)
- 0x1C IRQ_EN (RW, bit0)
- 0x20 CYCLES (RO)
- Unmapped offsets: read 0; any access sets pslverr.

APB behaviour:
- pready is always 1 (zero wait states).
- A write takes effect on the access cycle (psel & penable & pwrite).
- prdata is driven combinationally from the register state during the access phase, and is 0 otherwise.

FSM states: IDLE, LAUNCH, BUSY.
- IDLE: a CMD write with bit0=1 checks WIDTH. If WIDTH==0, err is set and the FSM stays in IDLE. Otherwise it clears done and CYCLES and moves to LAUNCH.
- LAUNCH: start_o=1 for exactly this cycle; then move to BUSY.
- BUSY: CYCLES increments each cycle and saturates at 32'hFFFF_FFFF. On done_i, done is set and the FSM moves to IDLE.
- busy reads 1 in both LAUNCH and BUSY.

Writes during LAUNCH/BUSY:
- Writes to MAT_A, MAT_B, MAT_C, WIDTH and CMD are ignored and assert pslverr.
- Writes to STATUS and IRQ_EN are accepted.

Other rules:
- done_i in IDLE or LAUNCH is ignored.
- A W1C of done in the same cycle as the done_i set: the set wins.
- A W1C of err in the same cycle as an err set: the set wins.

## Timing
- Reset values:
  - start_o = 0, irq_o = 0
  - mat_* outputs = the *_RST parameters
  - done, err, IRQ_EN, CYCLES = 0
  - FSM = IDLE
- Launch: a start write completing in cycle t gives start_o=1 and busy=1 in cycle t+1. CYCLES=0 at t+1.
- Completion: done_i in cycle t gives busy=0, done=1 and FSM=IDLE in cycle t+1. irq_o=1 at t+1 if IRQ_EN=1.
- Cycle count: CYCLES equals the number of BUSY cycles before done_i, counting the done_i cycle.
- A new start is accepted in the cycle after the FSM returns to IDLE.
- Reset mid-operation returns every register and output to its reset value immediately; no start_o is emitted.
- mat_* outputs are registered and stable throughout LAUNCH and BUSY.

## Structure
- Package mme_ctrl_pkg holds:
  - register offset localparams
  - the FSM state enum (IDLE/LAUNCH/BUSY)
  - STATUS bit positions
- Sub-module mme_ctrl_regs: APB decode plus the register file, exporting the start request and W1C strobes.
- mme_ctrl top: the FSM and the cycle counter.

## Test plan
- Reset read: VERSION=0x0001_0000, MAT_B=0x1000, WIDTH=0x32, STATUS=0, irq_o=0, no pslverr.
- Configure and run:
  - Stimulus: write MAT_A=0x100, WIDTH=8, IRQ_EN=1, CMD=1; drive done_i 20 cycles after start_o.
  - Expected: exactly one start_o pulse; mat_a_addr_o=0x100; STATUS=0x2; CYCLES=21; irq_o=1.
- W1C: write STATUS=0x2 → irq_o=0 next cycle. Drive done_i and the W1C in the same cycle → done stays 1.
- Busy protection: during BUSY, write MAT_C=0xDEAD and CMD=1 → pslverr=1 on both, MAT_C unchanged, no second start_o.
- Error and decode: WIDTH=0 then CMD=1 → STATUS=0x4, no start_o. Read offset 0x3C → prdata=0, pslverr=1.
- Reset mid-run: assert rst_n low during BUSY → start_o=0, busy=0, addresses back to reset values, stray done_i afterwards ignored.
